fcs_strip: RTL and testbench

- Sits directly downstream of the preamble-cut stage in the XGMII receive path.
- Consumes the 64-bit Sof/Eof/Mod word stream after the preamble word is removed, and removes the trailing 4-byte FCS, re-aligning Eof and Mod when the FCS straddles a word boundary.
- Reports the stripped frame length and an error vector on the Eof word (preamble error, runt, giant, abort).
- Output feeds the timestamp/capture stage.

---
 rtl/fcs_strip.sv | 165 ++++++++++++++++
 tb/tb_fcs_strip.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fcs_strip.sv
// fcs_strip: removes the trailing 4-byte FCS from the Sof/Eof/Mod word stream.
// When the FCS spills into the last word, that word is dropped and the previous
// word is re-marked as the last word. Length and error flags are reported on the Eof word.
module fcs_strip #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PreRxdv,
  input  logic [63:0] PreRxd,
  input  logic        PreRxSof,
  input  logic        PreRxEof,
  input  logic [2:0]  PreRxMod,
  input  logic        PreErr,
  output logic        FcsRxdv,
  output logic [63:0] FcsRxd,
  output logic        FcsRxSof,
  output logic        FcsRxEof,
  output logic [2:0]  FcsRxMod,
  output logic [15:0] FcsLen,
  output logic [3:0]  FcsErrVec
);

  // Valid-byte count of a word: a Mod value of 0 means all 8 bytes are valid.
  function automatic logic [3:0] nbytes(input logic [2:0] m);
    return (m == 3'd0) ? 4'd8 : {1'b0, m};
  endfunction

  // S1: registered input word
  logic        s1_vld_q, s1_vld_d;
  logic [63:0] s1_data_q, s1_data_d;
  logic        s1_sof_q, s1_sof_d;
  logic        s1_eof_q, s1_eof_d;
  logic [2:0]  s1_mod_q, s1_mod_d;
  logic        s1_err_q, s1_err_d;

  // S2: output register
  logic        s2_vld_q, s2_vld_d;
  logic [63:0] s2_data_q, s2_data_d;
  logic        s2_sof_q, s2_sof_d;
  logic        s2_eof_q, s2_eof_d;
  logic [2:0]  s2_mod_q, s2_mod_d;
  logic [15:0] s2_len_q, s2_len_d;
  logic [3:0]  s2_err_q, s2_err_d;

  // Frame tracking for the word moving from S1 into S2
  logic        in_frame_q, in_frame_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pre_err_q, pre_err_d;

  logic        accept, single, open_after, abort, fold, is_eof, perr;
  logic [3:0]  w_v, n_v, fold_v, strip_v, out_bytes;
  logic [2:0]  eof_mod;
  logic [16:0] sum;
  logic [15:0] len;

  // Next-state: the word leaving S1 is classified using a look-ahead at the
  // input word that is about to enter S1 (abort on Sof/gap, fold on a short Eof).
  always_comb begin
    s1_vld_d  = PreRxdv;
    s1_data_d = PreRxd;
    s1_sof_d  = PreRxSof;
    s1_eof_d  = PreRxEof;
    s1_mod_d  = PreRxMod;
    s1_err_d  = PreErr;

    s2_vld_d  = 1'b0;
    s2_data_d = 64'd0;
    s2_sof_d  = 1'b0;
    s2_eof_d  = 1'b0;
    s2_mod_d  = 3'd0;
    s2_len_d  = 16'd0;
    s2_err_d  = 4'd0;

    in_frame_d = 1'b0;
    cnt_d      = cnt_q;
    pre_err_d  = pre_err_q;

    w_v        = nbytes(s1_mod_q);
    n_v        = nbytes(PreRxMod);
    accept     = s1_vld_q && (s1_sof_q || in_frame_q);
    single     = s1_sof_q && s1_eof_q;
    open_after = accept && !s1_eof_q;
    abort      = open_after && (!PreRxdv || PreRxSof);
    fold       = open_after && PreRxdv && !PreRxSof && PreRxEof && (n_v <= 4'd4);
    is_eof     = s1_eof_q || abort || fold;
    fold_v     = n_v + 4'd4;
    strip_v    = w_v - 4'd4;

    eof_mod = 3'd0;
    if (abort)         eof_mod = 3'd0;
    else if (fold)     eof_mod = fold_v[2:0];
    else if (single)   eof_mod = s1_mod_q;
    else if (s1_eof_q) eof_mod = strip_v[2:0];

    out_bytes = is_eof ? nbytes(eof_mod) : 4'd8;
    sum       = {1'b0, (s1_sof_q ? 16'd0 : cnt_q)} + {13'd0, out_bytes};
    len       = sum[16] ? 16'hFFFF : sum[15:0];
    perr      = s1_sof_q ? s1_err_q : pre_err_q;

    if (accept) begin
      s2_vld_d   = 1'b1;
      s2_data_d  = s1_data_q;
      s2_sof_d   = s1_sof_q;
      s2_eof_d   = is_eof;
      cnt_d      = len;
      pre_err_d  = perr;
      in_frame_d = !is_eof;
      if (is_eof) begin
        s2_mod_d = eof_mod;
        s2_len_d = len;
        s2_err_d = {abort, (len > 16'(MAX_LEN)), (single || (len < 16'(MIN_LEN))), perr};
      end
    end
  end

  // Pipeline and frame-state registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld_q   <= 1'b0;
      s1_data_q  <= 64'd0;
      s1_sof_q   <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_mod_q   <= 3'd0;
      s1_err_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_data_q  <= 64'd0;
      s2_sof_q   <= 1'b0;
      s2_eof_q   <= 1'b0;
      s2_mod_q   <= 3'd0;
      s2_len_q   <= 16'd0;
      s2_err_q   <= 4'd0;
      in_frame_q <= 1'b0;
      cnt_q      <= 16'd0;
      pre_err_q  <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_data_q  <= s1_data_d;
      s1_sof_q   <= s1_sof_d;
      s1_eof_q   <= s1_eof_d;
      s1_mod_q   <= s1_mod_d;
      s1_err_q   <= s1_err_d;
      s2_vld_q   <= s2_vld_d;
      s2_data_q  <= s2_data_d;
      s2_sof_q   <= s2_sof_d;
      s2_eof_q   <= s2_eof_d;
      s2_mod_q   <= s2_mod_d;
      s2_len_q   <= s2_len_d;
      s2_err_q   <= s2_err_d;
      in_frame_q <= in_frame_d;
      cnt_q      <= cnt_d;
      pre_err_q  <= pre_err_d;
    end
  end

  assign FcsRxdv   = s2_vld_q;
  assign FcsRxd    = s2_data_q;
  assign FcsRxSof  = s2_sof_q;
  assign FcsRxEof  = s2_eof_q;
  assign FcsRxMod  = s2_mod_q;
  assign FcsLen    = s2_len_q;
  assign FcsErrVec = s2_err_q;

endmodule

// File: tb/tb_fcs_strip.sv
// Self-checking bench for fcs_strip: frames are described by byte length and the
// expected output words are derived from the stripped length, not from the RTL.
module tb_fcs_strip;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PreRxdv = 1'b0;
  logic [63:0] PreRxd = 64'd0;
  logic        PreRxSof = 1'b0;
  logic        PreRxEof = 1'b0;
  logic [2:0]  PreRxMod = 3'd0;
  logic        PreErr = 1'b0;
  logic        FcsRxdv;
  logic [63:0] FcsRxd;
  logic        FcsRxSof;
  logic        FcsRxEof;
  logic [2:0]  FcsRxMod;
  logic [15:0] FcsLen;
  logic [3:0]  FcsErrVec;

  fcs_strip #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .Clk(Clk), .Reset(Reset), .PreRxdv(PreRxdv), .PreRxd(PreRxd),
    .PreRxSof(PreRxSof), .PreRxEof(PreRxEof), .PreRxMod(PreRxMod), .PreErr(PreErr),
    .FcsRxdv(FcsRxdv), .FcsRxd(FcsRxd), .FcsRxSof(FcsRxSof), .FcsRxEof(FcsRxEof),
    .FcsRxMod(FcsRxMod), .FcsLen(FcsLen), .FcsErrVec(FcsErrVec)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        sof;
    logic        eof;
    logic [2:0]  mod;
    logic [15:0] len;
    logic [3:0]  err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic sof, input logic eof,
                            input logic [2:0] mod, input logic err, input logic rst);
    @(posedge Clk); #1;
    PreRxdv = 1'b1; PreRxd = d; PreRxSof = sof; PreRxEof = eof;
    PreRxMod = mod; PreErr = err; Reset = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      PreRxdv = 1'b0; PreRxd = 64'd0; PreRxSof = 1'b0; PreRxEof = 1'b0;
      PreRxMod = 3'd0; PreErr = 1'b0; Reset = 1'b0;
    end
  endtask

  // Reference model: a frame of nbytes (FCS included) becomes the first nbytes-4
  // bytes; a single-word frame passes whole; a truncated frame of k words becomes
  // k full words closed with abort.
  task automatic send_frame(input int nbytes, input bit perr, input bit trunc, input int kwords);
    int nwords, stripped, out_words;
    logic [63:0] d;
    logic last;
    exp_t e;
    if (trunc) begin
      nwords   = kwords;
      stripped = 8 * kwords;
    end else begin
      nwords   = (nbytes + 7) / 8;
      stripped = (nwords == 1) ? nbytes : nbytes - 4;
    end
    out_words = (stripped + 7) / 8;
    for (int w = 0; w < nwords; w++) begin
      d    = {$urandom, $urandom};
      last = !trunc && (w == nwords - 1);
      drive_word(d, w == 0, last, last ? 3'(nbytes % 8) : 3'd0, (w == 0) ? perr : 1'b0, 1'b0);
      if (w < out_words) begin
        e.data = d;
        e.sof  = (w == 0);
        e.eof  = (w == out_words - 1);
        e.mod  = e.eof ? 3'(stripped % 8) : 3'd0;
        e.len  = e.eof ? 16'(stripped) : 16'd0;
        e.err  = e.eof ? {trunc, (stripped > MAX_LEN), ((stripped < MIN_LEN) || (nwords == 1)), perr}
                       : 4'd0;
        e.cyc  = cyc + 2;
        q.push_back(e);
      end
    end
  endtask

  // Output monitor: every valid word must match the head of the expected queue
  // at the expected cycle; idle cycles must show all qualifiers at zero.
  exp_t me;
  always @(negedge Clk) begin
    if (mon_en) begin
      if (FcsRxdv === 1'b1) begin
        chk("word_expected", 128'(q.size() > 0), 128'(1));
        if (q.size() > 0) begin
          me = q.pop_front();
          chk("data", 128'(FcsRxd), 128'(me.data));
          chk("ctrl", 128'({FcsRxSof, FcsRxEof, FcsRxMod, FcsLen, FcsErrVec}),
              128'({me.sof, me.eof, me.mod, me.len, me.err}));
          chk("latency_cycle", 128'(cyc), 128'(me.cyc));
        end
      end else begin
        chk("idle_zero", 128'({FcsRxdv, FcsRxSof, FcsRxEof, FcsRxMod, FcsLen, FcsErrVec}), 128'(0));
      end
    end
  end

  initial begin
    logic [63:0] d;
    exp_t e;
    int nb;

    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_outputs", 128'({FcsRxdv, FcsRxSof, FcsRxEof, FcsRxMod, FcsLen, FcsErrVec, FcsRxd}), 128'(0));
    mon_en = 1'b1;
    idle(2);

    // Directed frames; each follows the previous one back-to-back
    send_frame(64, 1'b0, 1'b0, 0);
    send_frame(65, 1'b0, 1'b0, 0);
    send_frame(68, 1'b0, 1'b0, 0);
    send_frame(1522, 1'b0, 1'b0, 0);
    send_frame(40, 1'b0, 1'b0, 0);
    send_frame(40, 1'b1, 1'b0, 0);
    send_frame(6, 1'b0, 1'b0, 0);
    send_frame(10, 1'b0, 1'b0, 0);
    idle(3);

    // Abort by a new Sof, then abort by a gap
    send_frame(0, 1'b0, 1'b1, 5);
    send_frame(64, 1'b0, 1'b0, 0);
    idle(2);
    send_frame(0, 1'b1, 1'b1, 5);
    idle(1);
    send_frame(70, 1'b0, 1'b0, 0);
    idle(4);

    // Reset for one cycle mid-frame; words 0..3 reach the output before it lands
    for (int w = 0; w < 8; w++) begin
      d = {$urandom, $urandom};
      drive_word(d, w == 0, w == 7, 3'd0, 1'b0, w == 5);
      if (w <= 3) begin
        e.data = d; e.sof = (w == 0); e.eof = 1'b0; e.mod = 3'd0;
        e.len = 16'd0; e.err = 4'd0; e.cyc = cyc + 2;
        q.push_back(e);
      end
    end
    idle(4);
    send_frame(64, 1'b0, 1'b0, 0);

    // Random frames, some truncated, with random gaps of 0..2 cycles
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 5) == 0)
        send_frame(0, 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(1, 10)));
      else begin
        nb = int'($urandom_range(1, 200));
        send_frame(nb, 1'($urandom_range(0, 1)), 1'b0, 0);
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
    chk("drain_empty", 128'(q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
